id_sample_sequencer: RTL and testbench
======================================

Name: id_sample_sequencer

Overview:
- Sequences the discrete-input sampler: it arbitrates between three requesters, decodes the granted source group into one-hot gate enables, and runs a clear / gate / hold sequence on the DM latches.
- It captures the 6 DM bits into a holding register.
- It sits between the computer process-input path, the telemetry scan and the error-monitor path on one side, and the sampler's group-enable, clear and timing inputs on the other.

Parameters:
- PHASE_CLKS, 4, clock cycles per sequence phase (CLR, GATE, HOLD); legal range 1..255.
- STARVE_LIM, 3, consecutive lost arbitrations after which TLM is promoted to top priority; legal range 1..15.

Ports:
- SIM_CLK  in  1  system clock.
- SIM_RST  in  1  synchronous, active-low reset.
- ECS_REQ  in  1  error-monitor sample request; implied group 1.
- PIO_REQ  in  1  computer process-input sample request.
- PIO_GRP  in  3  source group for PIO.
- TLM_REQ  in  1  telemetry sample request.
- TLM_GRP  in  3  source group for TLM.
- DM_IN  in  6  sampler outputs {DM10A,DM9A,DM8A,DM7A,DM5B,DM4B}.
- ECS_GNT, PIO_GNT, TLM_GNT  out  1 each  grant, held from grant through DONE.
- SRC_EN  out  8  one-hot group enable: bit0 CODE/CES, 1 EM, 2 SS, 3 DO, 4 ICR, 5 DINF, 6 PS, 7 unused.
- CLR_STB  out  1  clears DM latches (drives RESMV-type clear).
- GATE_STB  out  1  gate-timing strobe; sampler set pulses are valid only while high.
- DATA  out  6  captured DM bits.
- DATA_VLD  out  1  one-cycle pulse; DATA is valid.
- GRP_ERR  out  1  one-cycle pulse; the granted request named group 7.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (SIM_RST low at a clock edge): state IDLE; all outputs 0; DATA=0; phase counter 0; starve counter 0. Reset mid-sequence aborts immediately, drops SRC_EN and the strobes, and does not pulse DATA_VLD.
- States: IDLE -> CLR -> GATE -> HOLD -> DONE -> IDLE.
- IDLE:
  - Arbitration is evaluated every cycle.
  - Priority is ECS > PIO > TLM. If starve_cnt >= STARVE_LIM and TLM_REQ is high, TLM wins outright.
  - The winner's GNT rises on the next edge, and its group is latched into grp_q.
  - If the latched group is 7: GRP_ERR and GNT both pulse for that one cycle, the state stays IDLE, and nothing is sequenced.
- starve_cnt:
  - Increments (saturating at 15) on each grant issued while TLM_REQ was high but TLM lost.
  - Clears when TLM is granted.
  - Is unchanged otherwise.
- CLR: CLR_STB=1 and SRC_EN=0 for PHASE_CLKS cycles.
- GATE: SRC_EN=onehot(grp_q) and GATE_STB=1 for PHASE_CLKS cycles.
- HOLD:
  - SRC_EN stays asserted; GATE_STB=0; lasts PHASE_CLKS cycles.
  - DATA is loaded from DM_IN on the last HOLD cycle.
- DONE: one cycle. DATA_VLD=1, GNT is still high, SRC_EN=0. The next state is IDLE.
- GNT drops on the edge leaving DONE.
- A new grant can issue on the first IDLE cycle, so there is 1 idle cycle minimum between sequences.
- Latency: request high in IDLE -> DATA_VLD after 1 + 3*PHASE_CLKS + 1 cycles.
- Deasserting REQ mid-sequence is ignored; the sequence completes and DATA_VLD still pulses. A requester must hold REQ until GNT is seen.
- Group inputs are sampled only at grant; changes afterward are ignored.
- Simultaneous requests: exactly one GNT at any time. Losers wait and are not queued beyond their held REQ level.
- The phase counter is 8-bit. It counts 0..PHASE_CLKS-1 and wraps to 0 on each phase change.
- DATA holds its value until the next successful capture.

Decomposition:
- Shared package id_seq_pkg:
  - state enum (IDLE, CLR, GATE, HOLD, DONE);
  - 3-bit group codes GRP_CODE..GRP_PS and GRP_RSVD=7;
  - requester index constants;
  - function grp_onehot(3b) -> 8b.
- One sub-module: id_seq_arbiter (fixed priority plus starvation promotion, starve counter, grant encode). The sequencer FSM, phase counter and capture register stay in the top module.

Test Plan:
- Single PIO_REQ, PIO_GRP=4, PHASE_CLKS=4, DM_IN=6'b101101 -> PIO_GNT for 14 cycles; CLR_STB 4 cycles; SRC_EN=8'h10 for 8 cycles; GATE_STB high for the first 4 of those; DATA=6'b101101; DATA_VLD at cycle 14.
- ECS_REQ, PIO_REQ and TLM_REQ all raised together -> grant order ECS (SRC_EN=8'h02), then PIO, then TLM; never more than one GNT high.
- PIO and ECS requesting continuously with TLM_REQ held, STARVE_LIM=3 -> TLM is granted after exactly 3 lost grants; starve_cnt returns to 0.
- PIO_GRP=7 -> 1-cycle GRP_ERR plus PIO_GNT pulse; no CLR_STB; DATA unchanged; BUSY stays 0.
- SIM_RST low during GATE -> next cycle all outputs 0, no DATA_VLD; a request after reset runs a full clean sequence.
- PHASE_CLKS=1 with TLM_REQ dropped during CLR -> sequence completes in 5 cycles; DATA_VLD pulses; BUSY low afterwards.

Source files
------------

// File: rtl/id_seq_pkg.sv
// Shared definitions for the discrete-input sample sequencer.
//   seq_state_e : sequencer FSM states
//   GRP_*       : 3-bit source group codes (GRP_RSVD has no enable line)
//   REQ_*       : requester indices into grant / request vectors
//   smp_req_t   : one requester's request level plus its source group
//   grp_onehot  : group code -> one-hot SRC_EN pattern (reserved -> 0)
package id_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_GATE = 3'd2,
    ST_HOLD = 3'd3,
    ST_DONE = 3'd4
  } seq_state_e;

  localparam logic [2:0] GRP_CODE = 3'd0;
  localparam logic [2:0] GRP_EM   = 3'd1;
  localparam logic [2:0] GRP_SS   = 3'd2;
  localparam logic [2:0] GRP_DO   = 3'd3;
  localparam logic [2:0] GRP_ICR  = 3'd4;
  localparam logic [2:0] GRP_DINF = 3'd5;
  localparam logic [2:0] GRP_PS   = 3'd6;
  localparam logic [2:0] GRP_RSVD = 3'd7;

  localparam int NUM_REQ = 3;
  localparam int REQ_ECS = 0;
  localparam int REQ_PIO = 1;
  localparam int REQ_TLM = 2;

  typedef struct packed {
    logic       req;
    logic [2:0] grp;
  } smp_req_t;

  function automatic logic [7:0] grp_onehot(input logic [2:0] grp);
    logic [7:0] oh;
    oh = 8'b0;
    if (grp != GRP_RSVD) oh[grp] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/id_seq_arbiter.sv
// Requester arbiter: fixed priority ECS > PIO > TLM, with TLM promoted to
// top priority once it has lost STARVE_LIM consecutive grants.
//   gclk, grst_n : clock, synchronous active-low reset
//   req          : per-requester request level and group
//   issue        : a grant is being issued this cycle (updates starve count)
//   any_req      : at least one requester is asking
//   win_oh       : one-hot winner (valid whenever any_req)
//   win_grp      : group of the winner
module id_seq_arbiter
  import id_seq_pkg::*;
#(
  parameter int STARVE_LIM = 3
) (
  input  logic                      gclk,
  input  logic                      grst_n,
  input  smp_req_t [NUM_REQ-1:0]    req,
  input  logic                      issue,
  output logic                      any_req,
  output logic     [NUM_REQ-1:0]    win_oh,
  output logic     [2:0]            win_grp
);

  logic [3:0] starve_q;
  logic       promote;

  assign any_req = req[REQ_ECS].req | req[REQ_PIO].req | req[REQ_TLM].req;

  always_comb begin
    promote = req[REQ_TLM].req && (starve_q >= 4'(STARVE_LIM));
    win_oh  = '0;
    if (promote)               win_oh[REQ_TLM] = 1'b1;
    else if (req[REQ_ECS].req) win_oh[REQ_ECS] = 1'b1;
    else if (req[REQ_PIO].req) win_oh[REQ_PIO] = 1'b1;
    else if (req[REQ_TLM].req) win_oh[REQ_TLM] = 1'b1;
    win_grp = GRP_CODE;
    for (int i = 0; i < NUM_REQ; i++)
      if (win_oh[i]) win_grp = req[i].grp;
  end

  // Counts grants TLM lost while asking; saturates rather than wrapping so
  // a long starvation run can never fall back below the promotion limit.
  always_ff @(posedge gclk) begin
    if (!grst_n) begin
      starve_q <= '0;
    end else if (issue) begin
      if (win_oh[REQ_TLM])
        starve_q <= '0;
      else if (req[REQ_TLM].req && starve_q != 4'hF)
        starve_q <= starve_q + 4'd1;
    end
  end

endmodule

// File: rtl/id_sample_sequencer.sv
// Discrete-input sample sequencer. Grants one of ECS / PIO / TLM, then runs
// CLR -> GATE -> HOLD -> DONE on the DM latches and captures DM_IN.
//   SIM_CLK, SIM_RST        : clock, synchronous active-low reset
//   ECS_REQ                 : error-monitor request (group EM)
//   PIO_REQ/PIO_GRP         : process-input request and group
//   TLM_REQ/TLM_GRP         : telemetry request and group
//   DM_IN                   : sampler outputs
//   *_GNT                   : grant, held from grant cycle through DONE
//   SRC_EN                  : one-hot group enable during GATE and HOLD
//   CLR_STB, GATE_STB       : latch clear / gate timing strobes
//   DATA, DATA_VLD          : captured bits and their one-cycle valid
//   GRP_ERR                 : granted request named the reserved group
//   BUSY                    : sequencer not idle
module id_sample_sequencer
  import id_seq_pkg::*;
#(
  parameter int PHASE_CLKS = 4,
  parameter int STARVE_LIM = 3
) (
  input  logic       SIM_CLK,
  input  logic       SIM_RST,
  input  logic       ECS_REQ,
  input  logic       PIO_REQ,
  input  logic [2:0] PIO_GRP,
  input  logic       TLM_REQ,
  input  logic [2:0] TLM_GRP,
  input  logic [5:0] DM_IN,
  output logic       ECS_GNT,
  output logic       PIO_GNT,
  output logic       TLM_GNT,
  output logic [7:0] SRC_EN,
  output logic       CLR_STB,
  output logic       GATE_STB,
  output logic [5:0] DATA,
  output logic       DATA_VLD,
  output logic       GRP_ERR,
  output logic       BUSY
);

  seq_state_e                 state_q, state_d;
  logic       [7:0]           phase_q;
  logic       [NUM_REQ-1:0]   gnt_q;
  logic       [2:0]           grp_q;
  logic       [5:0]           data_q;
  smp_req_t   [NUM_REQ-1:0]   reqs;
  logic                       any_req, issue, in_phase, phase_last, grp_err_w;
  logic       [NUM_REQ-1:0]   win_oh;
  logic       [2:0]           win_grp;

  always_comb begin
    reqs[REQ_ECS] = {ECS_REQ, GRP_EM};
    reqs[REQ_PIO] = {PIO_REQ, PIO_GRP};
    reqs[REQ_TLM] = {TLM_REQ, TLM_GRP};
  end

  // A grant is only issued from IDLE with no grant outstanding, so the
  // granted IDLE cycle cannot stack a second grant on top of the first.
  assign issue      = (state_q == ST_IDLE) && (gnt_q == '0) && any_req;
  assign in_phase   = (state_q == ST_CLR) || (state_q == ST_GATE) || (state_q == ST_HOLD);
  assign phase_last = (phase_q == 8'(PHASE_CLKS - 1));
  assign grp_err_w  = (state_q == ST_IDLE) && (gnt_q != '0) && (grp_q == GRP_RSVD);

  id_seq_arbiter #(.STARVE_LIM(STARVE_LIM)) u_arb (
    .gclk    (SIM_CLK),
    .grst_n  (SIM_RST),
    .req     (reqs),
    .issue   (issue),
    .any_req (any_req),
    .win_oh  (win_oh),
    .win_grp (win_grp)
  );

  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (gnt_q != '0 && grp_q != GRP_RSVD) state_d = ST_CLR;
      ST_CLR:  if (phase_last) state_d = ST_GATE;
      ST_GATE: if (phase_last) state_d = ST_HOLD;
      ST_HOLD: if (phase_last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST) begin
      phase_q <= '0;
      gnt_q   <= '0;
      grp_q   <= GRP_CODE;
      data_q  <= '0;
    end else begin
      if (in_phase && !phase_last) phase_q <= phase_q + 8'd1;
      else                         phase_q <= '0;
      if (issue) begin
        gnt_q <= win_oh;
        grp_q <= win_grp;
      end else if (state_q == ST_DONE || grp_err_w) begin
        gnt_q <= '0;
      end
      if (state_q == ST_HOLD && phase_last) data_q <= DM_IN;
    end
  end

  always_comb begin
    ECS_GNT  = gnt_q[REQ_ECS];
    PIO_GNT  = gnt_q[REQ_PIO];
    TLM_GNT  = gnt_q[REQ_TLM];
    CLR_STB  = (state_q == ST_CLR);
    GATE_STB = (state_q == ST_GATE);
    SRC_EN   = (state_q == ST_GATE || state_q == ST_HOLD) ? grp_onehot(grp_q) : 8'h00;
    DATA     = data_q;
    DATA_VLD = (state_q == ST_DONE);
    GRP_ERR  = grp_err_w;
    BUSY     = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_id_sample_sequencer.sv
module tb_id_sample_sequencer;

  logic       SIM_CLK = 1'b0;
  logic       SIM_RST = 1'b0;
  logic       ECS_REQ = 1'b0, PIO_REQ = 1'b0, TLM_REQ = 1'b0;
  logic [2:0] PIO_GRP = 3'd0, TLM_GRP = 3'd0;
  logic [5:0] DM_IN = 6'd0;

  // instance a: PHASE_CLKS=4, instance b: PHASE_CLKS=1
  logic       ecs_gnt_a, pio_gnt_a, tlm_gnt_a, clr_stb_a, gate_stb_a, data_vld_a, grp_err_a, busy_a;
  logic [7:0] src_en_a;
  logic [5:0] data_a;
  logic       ecs_gnt_b, pio_gnt_b, tlm_gnt_b, clr_stb_b, gate_stb_b, data_vld_b, grp_err_b, busy_b;
  logic [7:0] src_en_b;
  logic [5:0] data_b;
  logic [21:0] outs_a, outs_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 SIM_CLK = ~SIM_CLK;

  assign outs_a = {ecs_gnt_a, pio_gnt_a, tlm_gnt_a, src_en_a, clr_stb_a, gate_stb_a, data_a, data_vld_a, grp_err_a, busy_a};
  assign outs_b = {ecs_gnt_b, pio_gnt_b, tlm_gnt_b, src_en_b, clr_stb_b, gate_stb_b, data_b, data_vld_b, grp_err_b, busy_b};

  id_sample_sequencer #(.PHASE_CLKS(4), .STARVE_LIM(3)) u_dut_a (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .ECS_REQ(ECS_REQ), .PIO_REQ(PIO_REQ), .PIO_GRP(PIO_GRP),
    .TLM_REQ(TLM_REQ), .TLM_GRP(TLM_GRP), .DM_IN(DM_IN),
    .ECS_GNT(ecs_gnt_a), .PIO_GNT(pio_gnt_a), .TLM_GNT(tlm_gnt_a), .SRC_EN(src_en_a),
    .CLR_STB(clr_stb_a), .GATE_STB(gate_stb_a), .DATA(data_a), .DATA_VLD(data_vld_a),
    .GRP_ERR(grp_err_a), .BUSY(busy_a));

  id_sample_sequencer #(.PHASE_CLKS(1), .STARVE_LIM(3)) u_dut_b (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .ECS_REQ(ECS_REQ), .PIO_REQ(PIO_REQ), .PIO_GRP(PIO_GRP),
    .TLM_REQ(TLM_REQ), .TLM_GRP(TLM_GRP), .DM_IN(DM_IN),
    .ECS_GNT(ecs_gnt_b), .PIO_GNT(pio_gnt_b), .TLM_GNT(tlm_gnt_b), .SRC_EN(src_en_b),
    .CLR_STB(clr_stb_b), .GATE_STB(gate_stb_b), .DATA(data_b), .DATA_VLD(data_vld_b),
    .GRP_ERR(grp_err_b), .BUSY(busy_b));

  task automatic step();
    @(posedge SIM_CLK);
    #1;
  endtask

  task automatic do_reset();
    SIM_RST = 1'b0;
    step();
    SIM_RST = 1'b1;
  endtask

  task automatic test_reset();
    SIM_RST = 1'b0;
    step(); step();
    n_cmp++; if (outs_a !== 22'd0) begin n_err++; $display("FAIL reset_outs_a: got %0h want 0", outs_a); end
    n_cmp++; if (outs_b !== 22'd0) begin n_err++; $display("FAIL reset_outs_b: got %0h want 0", outs_b); end
    n_cmp++; if (u_dut_a.u_arb.starve_q !== 4'd0) begin n_err++; $display("FAIL reset_starve: got %0d want 0", u_dut_a.u_arb.starve_q); end
    SIM_RST = 1'b1;
  endtask

  task automatic test_single();
    int gnt_n = 0, clr_n = 0, clr_first = 0, src_n = 0, src_first = 0, gate_n = 0, gate_first = 0;
    int busy_n = 0, vld_at = 0, other = 0;
    logic [5:0] vld_data = 6'd0;
    PIO_REQ = 1'b1; PIO_GRP = 3'd4; DM_IN = 6'b101101;
    for (int i = 1; i <= 20; i++) begin
      step();
      gnt_n += int'(pio_gnt_a);
      other += int'(ecs_gnt_a) + int'(tlm_gnt_a);
      if (clr_stb_a) begin clr_n++; if (clr_first == 0) clr_first = i; end
      if (src_en_a == 8'h10) begin src_n++; if (src_first == 0) src_first = i; end
      else if (src_en_a != 8'h00) other++;
      if (gate_stb_a) begin gate_n++; if (gate_first == 0) gate_first = i; end
      busy_n += int'(busy_a);
      if (data_vld_a) begin vld_at = i; vld_data = data_a; end
      // group change after grant must be ignored
      if (pio_gnt_a) begin PIO_REQ = 1'b0; PIO_GRP = 3'd2; end
    end
    n_cmp++; if (gnt_n !== 14) begin n_err++; $display("FAIL single_gnt_len: got %0d want 14", gnt_n); end
    n_cmp++; if (clr_n !== 4) begin n_err++; $display("FAIL single_clr_len: got %0d want 4", clr_n); end
    n_cmp++; if (clr_first !== 2) begin n_err++; $display("FAIL single_clr_start: got %0d want 2", clr_first); end
    n_cmp++; if (src_n !== 8) begin n_err++; $display("FAIL single_src_len: got %0d want 8", src_n); end
    n_cmp++; if (src_first !== 6) begin n_err++; $display("FAIL single_src_start: got %0d want 6", src_first); end
    n_cmp++; if (gate_n !== 4) begin n_err++; $display("FAIL single_gate_len: got %0d want 4", gate_n); end
    n_cmp++; if (gate_first !== 6) begin n_err++; $display("FAIL single_gate_start: got %0d want 6", gate_first); end
    n_cmp++; if (busy_n !== 13) begin n_err++; $display("FAIL single_busy_len: got %0d want 13", busy_n); end
    n_cmp++; if (vld_at !== 14) begin n_err++; $display("FAIL single_vld_cycle: got %0d want 14", vld_at); end
    n_cmp++; if (vld_data !== 6'b101101) begin n_err++; $display("FAIL single_data: got %b want 101101", vld_data); end
    n_cmp++; if (other !== 0) begin n_err++; $display("FAIL single_stray: got %0d want 0", other); end
    n_cmp++; if (data_a !== 6'b101101) begin n_err++; $display("FAIL single_data_hold: got %b want 101101", data_a); end
  endtask

  task automatic test_grp_err();
    int stray = 0;
    DM_IN = 6'b000111;
    PIO_REQ = 1'b1; PIO_GRP = 3'd7;
    step();
    n_cmp++; if (pio_gnt_a !== 1'b1) begin n_err++; $display("FAIL grperr_gnt: got %b want 1", pio_gnt_a); end
    n_cmp++; if (grp_err_a !== 1'b1) begin n_err++; $display("FAIL grperr_pulse: got %b want 1", grp_err_a); end
    n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL grperr_busy: got %b want 0", busy_a); end
    PIO_REQ = 1'b0;
    step();
    n_cmp++; if ({pio_gnt_a, grp_err_a} !== 2'b00) begin n_err++; $display("FAIL grperr_drop: got %b want 00", {pio_gnt_a, grp_err_a}); end
    for (int i = 0; i < 6; i++) begin
      step();
      stray += int'(clr_stb_a) + int'(busy_a) + int'(data_vld_a) + int'(grp_err_a);
    end
    n_cmp++; if (stray !== 0) begin n_err++; $display("FAIL grperr_no_seq: got %0d want 0", stray); end
    n_cmp++; if (data_a !== 6'b101101) begin n_err++; $display("FAIL grperr_data: got %b want 101101", data_a); end
  endtask

  task automatic test_arbitration();
    logic [2:0] order [3];
    logic [7:0] src [3];
    logic [2:0] prev = 3'b000, cur;
    int k = 0, multi = 0;
    ECS_REQ = 1'b1; PIO_REQ = 1'b1; PIO_GRP = 3'd3; TLM_REQ = 1'b1; TLM_GRP = 3'd5;
    for (int i = 0; i < 3; i++) begin order[i] = 3'b000; src[i] = 8'h00; end
    for (int i = 0; i < 60; i++) begin
      step();
      cur = {tlm_gnt_a, pio_gnt_a, ecs_gnt_a};
      if ($countones(cur) > 1) multi++;
      if ($countones({tlm_gnt_b, pio_gnt_b, ecs_gnt_b}) > 1) multi++;
      if (prev == 3'b000 && cur != 3'b000 && k < 3) begin order[k] = cur; k++; end
      if (gate_stb_a && k > 0) src[k-1] = src_en_a;
      if (ecs_gnt_a) ECS_REQ = 1'b0;
      if (pio_gnt_a) PIO_REQ = 1'b0;
      if (tlm_gnt_a) TLM_REQ = 1'b0;
      prev = cur;
    end
    n_cmp++; if (k !== 3) begin n_err++; $display("FAIL arb_count: got %0d want 3", k); end
    n_cmp++; if (order[0] !== 3'b001) begin n_err++; $display("FAIL arb_first: got %b want 001", order[0]); end
    n_cmp++; if (order[1] !== 3'b010) begin n_err++; $display("FAIL arb_second: got %b want 010", order[1]); end
    n_cmp++; if (order[2] !== 3'b100) begin n_err++; $display("FAIL arb_third: got %b want 100", order[2]); end
    n_cmp++; if (src[0] !== 8'h02) begin n_err++; $display("FAIL arb_src_ecs: got %h want 02", src[0]); end
    n_cmp++; if (src[1] !== 8'h08) begin n_err++; $display("FAIL arb_src_pio: got %h want 08", src[1]); end
    n_cmp++; if (src[2] !== 8'h20) begin n_err++; $display("FAIL arb_src_tlm: got %h want 20", src[2]); end
    n_cmp++; if (multi !== 0) begin n_err++; $display("FAIL arb_one_gnt: got %0d want 0", multi); end
  endtask

  task automatic test_starvation();
    logic [2:0] order [4];
    logic [2:0] prev = 3'b000, cur;
    logic [3:0] sc3 = 4'hA, sc4 = 4'hA;
    int k = 0;
    bit idle = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) order[i] = 3'b000;
    ECS_REQ = 1'b1; PIO_REQ = 1'b1; PIO_GRP = 3'd2; TLM_REQ = 1'b1; TLM_GRP = 3'd6;
    for (int i = 0; i < 100 && k < 4; i++) begin
      step();
      cur = {tlm_gnt_a, pio_gnt_a, ecs_gnt_a};
      if (prev == 3'b000 && cur != 3'b000) begin
        order[k] = cur;
        if (k == 2) sc3 = u_dut_a.u_arb.starve_q;
        if (k == 3) sc4 = u_dut_a.u_arb.starve_q;
        k++;
      end
      prev = cur;
    end
    ECS_REQ = 1'b0; PIO_REQ = 1'b0; TLM_REQ = 1'b0;
    n_cmp++; if (k !== 4) begin n_err++; $display("FAIL starve_count: got %0d want 4", k); end
    n_cmp++; if ({order[0], order[1], order[2]} !== 9'b001001001) begin n_err++; $display("FAIL starve_lost: got %b want 001001001", {order[0], order[1], order[2]}); end
    n_cmp++; if (order[3] !== 3'b100) begin n_err++; $display("FAIL starve_promote: got %b want 100", order[3]); end
    n_cmp++; if (sc3 !== 4'd3) begin n_err++; $display("FAIL starve_cnt3: got %0d want 3", sc3); end
    n_cmp++; if (sc4 !== 4'd0) begin n_err++; $display("FAIL starve_clear: got %0d want 0", sc4); end
    for (int i = 0; i < 40 && !idle; i++) begin
      step();
      if (!busy_a && !tlm_gnt_a) idle = 1'b1;
    end
    n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL starve_idle_timeout: got %b want 1", idle); end
  endtask

  task automatic test_reset_mid();
    int vld_n = 0, vld_at = 0, src_n = 0;
    logic [5:0] vld_data = 6'd0;
    do_reset();
    ECS_REQ = 1'b1; DM_IN = 6'b110011;
    step();
    ECS_REQ = 1'b0;
    for (int i = 0; i < 5; i++) step();
    n_cmp++; if ({gate_stb_a, src_en_a} !== 9'h102) begin n_err++; $display("FAIL rmid_in_gate: got %h want 102", {gate_stb_a, src_en_a}); end
    SIM_RST = 1'b0;
    step();
    n_cmp++; if (outs_a !== 22'd0) begin n_err++; $display("FAIL rmid_outs: got %0h want 0", outs_a); end
    SIM_RST = 1'b1;
    for (int i = 0; i < 4; i++) begin step(); vld_n += int'(data_vld_a) + int'(busy_a); end
    n_cmp++; if (vld_n !== 0) begin n_err++; $display("FAIL rmid_no_vld: got %0d want 0", vld_n); end
    PIO_REQ = 1'b1; PIO_GRP = 3'd0; DM_IN = 6'b010011;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (pio_gnt_a) PIO_REQ = 1'b0;
      if (src_en_a == 8'h01) src_n++;
      if (data_vld_a) begin vld_at = i; vld_data = data_a; end
    end
    n_cmp++; if (vld_at !== 14) begin n_err++; $display("FAIL rmid_resume_vld: got %0d want 14", vld_at); end
    n_cmp++; if (vld_data !== 6'b010011) begin n_err++; $display("FAIL rmid_resume_data: got %b want 010011", vld_data); end
    n_cmp++; if (src_n !== 8) begin n_err++; $display("FAIL rmid_resume_src: got %0d want 8", src_n); end
  endtask

  task automatic test_phase1();
    do_reset();
    TLM_REQ = 1'b1; TLM_GRP = 3'd6; DM_IN = 6'b111000;
    step(); // grant
    n_cmp++; if ({tlm_gnt_b, busy_b} !== 2'b10) begin n_err++; $display("FAIL p1_grant: got %b want 10", {tlm_gnt_b, busy_b}); end
    step(); // CLR
    TLM_REQ = 1'b0;
    n_cmp++; if ({clr_stb_b, src_en_b} !== 9'h100) begin n_err++; $display("FAIL p1_clr: got %h want 100", {clr_stb_b, src_en_b}); end
    step(); // GATE
    n_cmp++; if ({gate_stb_b, src_en_b} !== 9'h140) begin n_err++; $display("FAIL p1_gate: got %h want 140", {gate_stb_b, src_en_b}); end
    step(); // HOLD
    n_cmp++; if ({gate_stb_b, src_en_b} !== 9'h040) begin n_err++; $display("FAIL p1_hold: got %h want 040", {gate_stb_b, src_en_b}); end
    step(); // DONE
    n_cmp++; if ({tlm_gnt_b, data_vld_b, src_en_b} !== 10'h300) begin n_err++; $display("FAIL p1_done: got %h want 300", {tlm_gnt_b, data_vld_b, src_en_b}); end
    n_cmp++; if (data_b !== 6'b111000) begin n_err++; $display("FAIL p1_data: got %b want 111000", data_b); end
    step();
    n_cmp++; if ({busy_b, tlm_gnt_b, data_vld_b} !== 3'b000) begin n_err++; $display("FAIL p1_after: got %b want 000", {busy_b, tlm_gnt_b, data_vld_b}); end
    for (int i = 0; i < 20; i++) step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_grp_err();
    test_arbitration();
    test_starvation();
    test_reset_mid();
    test_phase1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
